// File: rtl/id_hazard_ctrl_pkg.sv
// Shared constants for the ID-stage hazard controller: forwarding-select
// encoding and the select-width helper.
package id_hazard_ctrl_pkg;

    localparam int FWD_REGFILE = 0;
    localparam int STG_EX      = 1;

    function automatic int fwd_sel_w(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/div_busy_ctr.sv
// Divider busy down-counter: loads DIV_LAT on a divide issue, counts down to
// zero regardless of pipeline stalls, and is cleared when the divide is flushed.
module div_busy_ctr #(
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic clear,
    output logic div_busy
);

    localparam int CW = $clog2(DIV_LAT + 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
        end else if (load) begin
            div_cnt <= CW'(DIV_LAT);
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - CW'(1);
        end
    end

    assign div_busy = (div_cnt != '0);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage interlock and forwarding controller: shadow scoreboard of in-flight
// destinations (EX..WB), per-operand forward selects, RAW/load-use/HI-LO stalls.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter  int REG_W       = 5,
    parameter  int FWD_STAGES  = 3,
    parameter  int LOAD_STAGE  = 2,
    parameter  int DIV_LAT     = 32,
    parameter  int FLUSH_DEPTH = 1,
    localparam int SW          = fwd_sel_w(FWD_STAGES)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_valid,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [REG_W-1:0] dst,
    input  logic             dst_we,
    input  logic             is_load,
    input  logic             is_div,
    input  logic             use_hilo,
    input  logic             mem_stall,
    input  logic             flush,
    output logic [SW-1:0]    fwd_a,
    output logic [SW-1:0]    fwd_b,
    output logic             id_stall,
    output logic             issue,
    output logic             div_busy
);

    localparam logic [FWD_STAGES:1] FLUSH_MASK = FWD_STAGES'((1 << FLUSH_DEPTH) - 1);

    logic [FWD_STAGES:1] ent_v, ent_ld, ent_dv;
    logic [FWD_STAGES:1] in_v, in_ld, in_dv;
    logic [FWD_STAGES:1] ready;
    logic [REG_W-1:0]    ent_dst [1:FWD_STAGES];
    logic [REG_W-1:0]    in_dst  [1:FWD_STAGES];

    logic [SW-1:0] sel_a, sel_b;
    logic          haz_a, haz_b, div_haz, div_kill;

    for (genvar k = 1; k <= FWD_STAGES; k++) begin : g_stage
        if (k == STG_EX) begin : g_head
            assign in_v[k]   = issue & dst_we & (dst != '0);
            assign in_dst[k] = issue ? dst : '0;
            assign in_ld[k]  = issue & is_load;
            assign in_dv[k]  = issue & is_div;
        end else begin : g_tail
            // A killed instruction must not slip into the first surviving stage.
            localparam bit SRC_KILLED = ((k - 1) <= FLUSH_DEPTH);
            assign in_v[k]   = ent_v[k-1]  & ~(flush & SRC_KILLED);
            assign in_ld[k]  = ent_ld[k-1] & ~(flush & SRC_KILLED);
            assign in_dv[k]  = ent_dv[k-1] & ~(flush & SRC_KILLED);
            assign in_dst[k] = ent_dst[k-1];
        end

        assign ready[k] = ent_v[k] & (~ent_ld[k] | (k >= LOAD_STAGE));

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                ent_v[k]   <= 1'b0;
                ent_ld[k]  <= 1'b0;
                ent_dv[k]  <= 1'b0;
                ent_dst[k] <= '0;
            end else if (flush && FLUSH_MASK[k]) begin
                ent_v[k]   <= 1'b0;
                ent_ld[k]  <= 1'b0;
                ent_dv[k]  <= 1'b0;
                ent_dst[k] <= '0;
            end else if (!mem_stall) begin
                ent_v[k]   <= in_v[k];
                ent_ld[k]  <= in_ld[k];
                ent_dv[k]  <= in_dv[k];
                ent_dst[k] <= in_dst[k];
            end
        end
    end

    // Returns {hazard, select}; scanning oldest to youngest lets the youngest match win.
    function automatic logic [SW:0] lookup(input logic [REG_W-1:0] src, input logic used);
        logic [SW:0] res;
        res = {1'b0, SW'(FWD_REGFILE)};
        if (used && src != '0) begin
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (ent_v[k] && ent_dst[k] == src) begin
                    res = ready[k] ? {1'b0, SW'(k)} : {1'b1, SW'(FWD_REGFILE)};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        {haz_a, sel_a} = lookup(rs, use_rs);
        {haz_b, sel_b} = lookup(rt, use_rt);
    end

    assign div_haz  = (use_hilo | is_div) & div_busy;
    assign id_stall = resetn & (mem_stall | (id_valid & (haz_a | haz_b | div_haz)));
    assign issue    = resetn & id_valid & ~id_stall & ~flush;
    assign fwd_a    = resetn ? sel_a : SW'(FWD_REGFILE);
    assign fwd_b    = resetn ? sel_b : SW'(FWD_REGFILE);

    // issue is blocked under flush, so a divide sitting in ID never loads the counter.
    assign div_kill = flush & |(ent_dv & FLUSH_MASK);

    div_busy_ctr #(
        .DIV_LAT (DIV_LAT)
    ) u_div_ctr (
        .clk      (clk),
        .resetn   (resetn),
        .load     (issue & is_div),
        .clear    (div_kill),
        .div_busy (div_busy)
    );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: forwarding, load-use, divider interlock,
// mem_stall freeze and asynchronous reset with hand-computed expectations.
module tb_id_hazard_ctrl;

    localparam int DIV_LAT = 32;

    logic       clk, resetn;
    logic       id_valid, use_rs, use_rt, dst_we, is_load, is_div, use_hilo;
    logic       mem_stall, flush;
    logic [4:0] rs, rt, dst;
    logic [1:0] fwd_a, fwd_b;
    logic       id_stall, issue, div_busy;

    int checks = 0;
    int errors = 0;

    id_hazard_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .id_valid  (id_valid),
        .rs        (rs),
        .rt        (rt),
        .use_rs    (use_rs),
        .use_rt    (use_rt),
        .dst       (dst),
        .dst_we    (dst_we),
        .is_load   (is_load),
        .is_div    (is_div),
        .use_hilo  (use_hilo),
        .mem_stall (mem_stall),
        .flush     (flush),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .id_stall  (id_stall),
        .issue     (issue),
        .div_busy  (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic ua,
                         input logic [4:0] b, input logic ub, input logic [4:0] d,
                         input logic we, input logic ld, input logic dv, input logic hl);
        id_valid = v;  rs = a;  use_rs = ua;  rt = b;  use_rt = ub;
        dst = d;  dst_we = we;  is_load = ld;  is_div = dv;  use_hilo = hl;
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic test_reset();
        resetn = 1'b0;  mem_stall = 1'b1;  flush = 1'b0;
        drive(1, 3, 1, 3, 1, 3, 1, 0, 1, 1);
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL rst_issue got %b exp 0", issue); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", id_stall); end
        checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL rst_fwd got %0d/%0d exp 0/0", fwd_a, fwd_b); end
        cyc();
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL rst_div_busy got %b exp 0", div_busy); end
        mem_stall = 1'b0;
        idle(0);
        @(negedge clk);
        resetn = 1'b1;
        cyc();
    endtask

    task automatic test_ex_fwd();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        checks++; if (issue !== 1'b1 || fwd_a !== 2'd0) begin errors++; $display("FAIL ex_first got issue=%b fwd_a=%0d exp 1/0", issue, fwd_a); end
        cyc();
        drive(1, 3, 1, 7, 1, 0, 0, 0, 0, 0);
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL ex_fwd_a got %0d exp 1", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL ex_fwd_b got %0d exp 0", fwd_b); end
        checks++; if (id_stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL ex_issue got stall=%b issue=%b exp 0/1", id_stall, issue); end
        cyc();
        idle(3);
    endtask

    task automatic test_load_use();
        drive(1, 29, 1, 0, 0, 4, 1, 1, 0, 0);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL lw_issue got %b exp 1", issue); end
        cyc();
        drive(1, 0, 1, 4, 1, 9, 1, 0, 0, 0);
        checks++; if (id_stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL lu_stall got stall=%b issue=%b exp 1/0", id_stall, issue); end
        cyc();
        checks++; if (id_stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL lu_release got stall=%b issue=%b exp 0/1", id_stall, issue); end
        checks++; if (fwd_b !== 2'd2 || fwd_a !== 2'd0) begin errors++; $display("FAIL lu_fwd got a=%0d b=%0d exp 0/2", fwd_a, fwd_b); end
        cyc();
        idle(3);
    endtask

    task automatic test_youngest();
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
        cyc();
        drive(1, 8, 1, 0, 0, 5, 1, 0, 0, 0);
        cyc();
        // readers do not write, so each one pushes the two $5 writers one stage deeper
        drive(1, 5, 1, 5, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL young_a got %0d exp 1", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL unused_b got %0d exp 0", fwd_b); end
        cyc();
        drive(1, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd2) begin errors++; $display("FAIL zero_reg got a=%0d b=%0d exp 0/2", fwd_a, fwd_b); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL zero_reg_stall got %b exp 0", id_stall); end
        cyc();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_a !== 2'd3) begin errors++; $display("FAIL wb_fwd got %0d exp 3", fwd_a); end
        cyc();
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL retired_fwd got %0d exp 0", fwd_a); end
        cyc();
        idle(3);
    endtask

    task automatic test_div();
        int n;
        drive(1, 8, 1, 9, 1, 0, 0, 0, 1, 0);
        checks++; if (issue !== 1'b1 || div_busy !== 1'b0) begin errors++; $display("FAIL div_issue got issue=%b busy=%b exp 1/0", issue, div_busy); end
        cyc();
        drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
        n = 0;
        while (id_stall === 1'b1 && n < 100) begin
            n++;
            cyc();
        end
        checks++; if (n != DIV_LAT) begin errors++; $display("FAIL div_stall_len got %0d exp %0d", n, DIV_LAT); end
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL mflo_issue got %b exp 1", issue); end
        cyc();
        idle(0);
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL div_done got %b exp 0", div_busy); end
        drive(1, 8, 1, 9, 1, 0, 0, 0, 1, 0);
        cyc();
        flush = 1'b1;
        drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
        checks++; if (issue !== 1'b0 || id_stall !== 1'b1) begin errors++; $display("FAIL flush_haz got issue=%b stall=%b exp 0/1", issue, id_stall); end
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL div_busy_pre got %b exp 1", div_busy); end
        cyc();
        flush = 1'b0;
        #1;
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL div_flush got %b exp 0", div_busy); end
        checks++; if (id_stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL post_flush got stall=%b issue=%b exp 0/1", id_stall, issue); end
        cyc();
        idle(3);
    endtask

    task automatic test_mem_stall();
        drive(1, 29, 1, 0, 0, 6, 1, 1, 0, 0);
        cyc();
        drive(1, 1, 1, 2, 1, 11, 1, 0, 0, 0);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL ms_addu got %b exp 1", issue); end
        cyc();
        mem_stall = 1'b1;
        drive(1, 11, 1, 6, 1, 13, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (id_stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL ms_hold%0d got stall=%b issue=%b exp 1/0", i, id_stall, issue); end
            checks++; if (fwd_a !== 2'd1 || fwd_b !== 2'd2) begin errors++; $display("FAIL ms_frozen%0d got a=%0d b=%0d exp 1/2", i, fwd_a, fwd_b); end
            cyc();
        end
        mem_stall = 1'b0;
        #1;
        checks++; if (id_stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL ms_release got stall=%b issue=%b exp 0/1", id_stall, issue); end
        checks++; if (fwd_a !== 2'd1 || fwd_b !== 2'd2) begin errors++; $display("FAIL ms_resume_fwd got a=%0d b=%0d exp 1/2", fwd_a, fwd_b); end
        cyc();
        idle(3);
    endtask

    task automatic test_reset_mid();
        drive(1, 8, 1, 9, 1, 0, 0, 0, 1, 0);
        cyc();
        idle(14);
        drive(1, 1, 1, 2, 1, 12, 1, 0, 0, 0);
        cyc();
        drive(1, 12, 1, 0, 0, 0, 0, 0, 0, 1);
        checks++; if (div_busy !== 1'b1 || fwd_a !== 2'd1) begin errors++; $display("FAIL pre_rst got busy=%b fwd_a=%0d exp 1/1", div_busy, fwd_a); end
        resetn = 1'b0;
        #1;
        checks++; if (div_busy !== 1'b0 || issue !== 1'b0 || id_stall !== 1'b0) begin errors++; $display("FAIL mid_rst got busy=%b issue=%b stall=%b exp 0/0/0", div_busy, issue, id_stall); end
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL mid_rst_fwd got %0d exp 0", fwd_a); end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++; if (fwd_a !== 2'd0 || issue !== 1'b1 || id_stall !== 1'b0) begin errors++; $display("FAIL post_rst got fwd_a=%0d issue=%b stall=%b exp 0/1/0", fwd_a, issue, id_stall); end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b exp 0", div_busy); end
        cyc();
        idle(2);
    endtask

    initial begin
        test_reset();
        test_ex_fwd();
        test_load_use();
        test_youngest();
        test_div();
        test_mem_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
